// File: rtl/seq_detect_multi.sv
// Serial detector for NUM_PAT runtime-programmable bit patterns with hit counter.
// Define SEQ_DETECT_STATUS_EN to add sticky per-pattern hit status.
module seq_detect_multi #(
    parameter int NUM_PAT = 2,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int SEL_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data_valid,
    input  logic               data_in,
    input  logic               overlap_en,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_enable,
`ifdef SEQ_DETECT_STATUS_EN
    input  logic               sticky_clr,
    output logic [NUM_PAT-1:0] hit_sticky,
`endif
    output logic [NUM_PAT-1:0] hit,
    output logic               data_out,
    output logic [CNT_W-1:0]   hit_count
);

    localparam logic [LEN_W:0]   LEN_LIM  = (LEN_W + 1)'(MAX_LEN);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
    localparam logic [SEL_W:0]   NPAT     = (SEL_W + 1)'(NUM_PAT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [MAX_LEN-1:0] r_pat [NUM_PAT];
    logic [LEN_W-1:0]   r_len [NUM_PAT];
    logic [NUM_PAT-1:0] r_en;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [NUM_PAT-1:0] r_hit;
    logic               r_dout;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_word;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W:0]     w_fill1;
    logic [NUM_PAT-1:0] w_match;
    logic [NUM_PAT-1:0] w_hit;
    logic               w_any;
    logic               w_cfg_ok;

    assign w_word   = {r_hist[MAX_LEN-2:0], data_in};
    assign w_fill1  = {1'b0, r_fill} + (LEN_W + 1)'(1);
    assign w_cfg_ok = cfg_we && ({1'b0, cfg_sel} < NPAT);

    // Compare only the low len bits of the candidate word per slot.
    always_comb begin
        w_match = '0;
        w_mask  = '0;
        for (int i = 0; i < NUM_PAT; i++) begin
            for (int j = 0; j < MAX_LEN; j++) begin
                w_mask[j] = (LEN_W'(j) < r_len[i]);
            end
            w_match[i] = r_en[i]
                && (r_len[i] != '0)
                && ({1'b0, r_len[i]} <= LEN_LIM)
                && (w_fill1 >= {1'b0, r_len[i]})
                && (((w_word ^ r_pat[i]) & w_mask) == '0);
        end
    end

    // A config write in the same cycle discards the data bit.
    assign w_hit = (data_valid && !w_cfg_ok) ? w_match : '0;
    assign w_any = |w_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_hit  <= '0;
            r_dout <= 1'b0;
            r_cnt  <= '0;
            r_en   <= '0;
            for (int i = 0; i < NUM_PAT; i++) begin
                r_pat[i] <= '0;
                r_len[i] <= '0;
            end
        end else begin
            r_hit  <= w_hit;
            r_dout <= w_any;
            if (w_any && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_cfg_ok) begin
                r_pat[cfg_sel] <= cfg_pattern;
                r_len[cfg_sel] <= cfg_len;
                r_en[cfg_sel]  <= cfg_enable;
                r_hist         <= '0;
                r_fill         <= '0;
            end else if (data_valid) begin
                if (!overlap_en && w_any) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_word;
                    if (r_fill != FILL_MAX) begin
                        r_fill <= r_fill + LEN_W'(1);
                    end
                end
            end
        end
    end

`ifdef SEQ_DETECT_STATUS_EN
    logic [NUM_PAT-1:0] r_sticky;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (r_sticky & ~{NUM_PAT{sticky_clr}}) | r_hit;
        end
    end

    assign hit_sticky = r_sticky;
`endif

    assign hit       = r_hit;
    assign data_out  = r_dout;
    assign hit_count = r_cnt;

endmodule

// File: tb/tb_seq_detect_multi.sv
// Scoreboard bench for seq_detect_multi: directed plan cases plus random traffic
// against a stream-level reference model.
module tb_seq_detect_multi;

    localparam int NP = 3;
    localparam int ML = 8;
    localparam int SW = 2;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          data_valid = 1'b0;
    logic          data_in = 1'b0;
    logic          overlap_en = 1'b1;
    logic          cfg_we = 1'b0;
    logic [SW-1:0] cfg_sel = '0;
    logic [ML-1:0] cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_enable = 1'b0;
    logic [NP-1:0] hit, hit3;
    logic          data_out, data_out3;
    logic [15:0]   hit_count;
    logic [2:0]    hit_count3;
`ifdef SEQ_DETECT_STATUS_EN
    logic          sticky_clr = 1'b0;
    logic [NP-1:0] hit_sticky, hit_sticky3;
`endif

    seq_detect_multi #(.NUM_PAT(NP), .MAX_LEN(ML), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .data_valid(data_valid),
        .data_in(data_in), .overlap_en(overlap_en), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_enable(cfg_enable),
`ifdef SEQ_DETECT_STATUS_EN
        .sticky_clr(sticky_clr), .hit_sticky(hit_sticky),
`endif
        .hit(hit), .data_out(data_out), .hit_count(hit_count)
    );

    seq_detect_multi #(.NUM_PAT(NP), .MAX_LEN(ML), .CNT_W(3)) u_dut3 (
        .clk(clk), .reset(reset), .data_valid(data_valid),
        .data_in(data_in), .overlap_en(overlap_en), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_enable(cfg_enable),
`ifdef SEQ_DETECT_STATUS_EN
        .sticky_clr(sticky_clr), .hit_sticky(hit_sticky3),
`endif
        .hit(hit3), .data_out(data_out3), .hit_count(hit_count3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] hit;
        logic          dout;
        int            c16;
        int            c3;
        logic [NP-1:0] stk;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference model: stream of bits since last clear, newest at the back.
    bit [ML-1:0] m_pat [NP];
    int          m_len [NP];
    bit          m_en [NP];
    bit          hist_q[$];
    bit [NP-1:0] m_hit;
    bit [NP-1:0] m_stk;
    int          m_c16;
    int          m_c3;
    bit          g_ov = 1'b1;
    bit          g_sclr = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req,
                     $time);
        end
    endtask

    function automatic bit slot_matches(input int i, input bit din);
        int n;
        bit b;
        if (!m_en[i] || m_len[i] < 1 || m_len[i] > ML) return 1'b0;
        n = hist_q.size();
        if (n + 1 < m_len[i]) return 1'b0;
        for (int k = 0; k < m_len[i]; k++) begin
            b = (k == 0) ? din : hist_q[n - k];
            if (b != m_pat[i][k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive(input bit rst, input bit we, input logic [SW-1:0] sel,
                         input logic [ML-1:0] pat, input logic [LW-1:0] len,
                         input bit ena, input bit dv, input bit din);
        bit [NP-1:0] hv;
        exp_t e;
        @(negedge clk);
        reset = rst;
        cfg_we = we;
        cfg_sel = sel;
        cfg_pattern = pat;
        cfg_len = len;
        cfg_enable = ena;
        data_valid = dv;
        data_in = din;
        overlap_en = g_ov;
`ifdef SEQ_DETECT_STATUS_EN
        sticky_clr = g_sclr;
`endif
        hv = '0;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                m_pat[i] = '0;
                m_len[i] = 0;
                m_en[i] = 1'b0;
            end
            hist_q.delete();
            m_c16 = 0;
            m_c3 = 0;
            m_stk = '0;
        end else begin
            m_stk = (m_stk & ~{NP{g_sclr}}) | m_hit;
            if (we && int'(sel) < NP) begin
                m_pat[sel] = pat;
                m_len[sel] = int'(len);
                m_en[sel] = ena;
                hist_q.delete();
            end else if (dv) begin
                for (int i = 0; i < NP; i++) hv[i] = slot_matches(i, din);
                if (!g_ov && hv != 0) begin
                    hist_q.delete();
                end else begin
                    hist_q.push_back(din);
                    if (hist_q.size() > ML) void'(hist_q.pop_front());
                end
            end
            if (hv != 0) begin
                if (m_c16 < 65535) m_c16++;
                if (m_c3 < 7) m_c3++;
            end
        end
        m_hit = hv;
        e.hit = hv;
        e.dout = (hv != 0);
        e.c16 = m_c16;
        e.c3 = m_c3;
        e.stk = m_stk;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, '0, '0, '0, 0, 0, 0);
        idle();
    endtask

    task automatic prog(input logic [SW-1:0] sel, input logic [ML-1:0] pat,
                        input logic [LW-1:0] len, input bit ena);
        drive(0, 1, sel, pat, len, ena, 0, 0);
    endtask

    task automatic bit_in(input bit din);
        drive(0, 0, '0, '0, '0, 0, 1, din);
    endtask

    // Bits are given first-to-last from the MSB of the low n bits.
    task automatic feed(input logic [15:0] bits, input int n, input int gaps);
        for (int k = n - 1; k >= 0; k--) begin
            bit_in(bits[k]);
            repeat (gaps) idle();
        end
    endtask

    task automatic chk_cnt(input string name, input int c16, input int c3);
        idle();
        @(posedge clk);
        #2;
        check({name, "_cnt16"}, 32'(hit_count), c16);
        check({name, "_cnt3"}, 32'(hit_count3), c3);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hit", 32'(hit), 32'(e.hit));
            check("data_out", 32'(data_out), 32'(e.dout));
            check("hit_count", 32'(hit_count), e.c16);
            check("hit_count3", 32'(hit_count3), e.c3);
            check("hit_w3", 32'(hit3), 32'(e.hit));
`ifdef SEQ_DETECT_STATUS_EN
            check("hit_sticky", 32'(hit_sticky), 32'(e.stk));
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        logic [LW-1:0] rl;
        m_hit = '0;
        do_reset();
        @(posedge clk);
        #2;
        check("reset_hit", 32'(hit), 0);
        check("reset_cnt", 32'(hit_count), 0);

        g_ov = 1'b1;
        prog(0, 8'b010, 3, 1);
        prog(1, 8'b1001, 4, 1);
        feed(16'b01001001, 8, 0);
        chk_cnt("overlap", 4, 4);

        do_reset();
        g_ov = 1'b0;
        prog(0, 8'b010, 3, 1);
        prog(1, 8'b1001, 4, 1);
        feed(16'b01001001, 8, 0);
        chk_cnt("nonoverlap", 2, 2);

        do_reset();
        g_ov = 1'b1;
        prog(0, 8'b010, 3, 1);
        prog(1, 8'b1001, 4, 1);
        feed(16'b01001001, 8, 2);
        chk_cnt("gaps", 4, 4);

        do_reset();
        prog(0, 8'b010, 3, 1);
        feed(16'b01, 2, 0);
        drive(0, 1, 1, 8'b1001, 4, 1, 1, 0);
        feed(16'b0, 1, 0);
        chk_cnt("cfg_clear", 0, 0);

        do_reset();
        prog(0, 8'b010, 3, 1);
        feed(16'b01, 2, 0);
        drive(0, 1, 3, 8'b1001, 4, 1, 0, 0);
        feed(16'b0, 1, 0);
        chk_cnt("cfg_badsel", 1, 1);

        do_reset();
        prog(2, 8'b10110011, 8, 1);
        prog(1, 8'b0, 0, 1);
        feed(16'b10110011, 8, 0);
        chk_cnt("len8", 1, 1);
        feed(16'b0000, 4, 0);
        chk_cnt("len0", 1, 1);

        do_reset();
        prog(0, 8'b1, 1, 1);
        feed(16'h1ff, 9, 0);
        chk_cnt("sat", 9, 7);
        feed(16'b11, 2, 0);
        chk_cnt("sat_hold", 11, 7);

        do_reset();
        prog(0, 8'b010, 3, 1);
        feed(16'b01, 2, 0);
        drive(1, 0, '0, '0, '0, 0, 0, 0);
        feed(16'b0, 1, 0);
        chk_cnt("rst_mid", 0, 0);
        feed(16'b010, 3, 0);
        chk_cnt("rst_disabled", 0, 0);

`ifdef SEQ_DETECT_STATUS_EN
        do_reset();
        prog(0, 8'b010, 3, 1);
        feed(16'b010, 3, 0);
        idle();
        @(posedge clk);
        #2;
        check("sticky_set", 32'(hit_sticky[0]), 1);
        g_sclr = 1'b1;
        idle();
        g_sclr = 1'b0;
        @(posedge clk);
        #2;
        check("sticky_clr", 32'(hit_sticky[0]), 0);
        feed(16'b010, 3, 0);
        g_sclr = 1'b1;
        idle();
        g_sclr = 1'b0;
        @(posedge clk);
        #2;
        check("sticky_setwins", 32'(hit_sticky[0]), 1);
`endif

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 19) == 0) g_ov = ~g_ov;
            g_sclr = ($urandom_range(0, 9) == 0);
            if (r < 4) begin
                rl = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 15))
                                                 : LW'($urandom_range(1, 4));
                drive(0, 1, SW'($urandom_range(0, 3)), ML'($urandom),
                      rl, ($urandom_range(0, 7) != 0),
                      $urandom_range(0, 1), $urandom_range(0, 1));
            end else if (r < 5) begin
                drive(1, $urandom_range(0, 1), '0, '0, '0, 0, 1, 1);
            end else begin
                drive(0, 0, '0, '0, '0, 0, ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 1));
            end
        end
        g_sclr = 1'b0;
        repeat (3) idle();
        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
